// File: rtl/ctrl_pkg.sv
// ctrl_pkg: RV32I opcodes, control encodings and the MEM/WB control bundle
package ctrl_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10
    } aluop_e;

    typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_type_e;

    typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10} sel_wb_e;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} mem_state_e;

    typedef struct packed {
        logic       rf_en;
        sel_wb_e    sel_wb;
        logic [4:0] rd;
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] mem_size;
    } wb_ctrl_t;

    // alt_add selects SUB (R-type only), alt_shift selects SRA/SRAI
    function automatic aluop_e alu_func(input logic [2:0] func3, input logic alt_add, input logic alt_shift);
        case (func3)
            3'b000:  return alt_add ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt_shift ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I decode of the DE/EX instruction into DE and MEM/WB controls
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output aluop_e      aluop,
    output logic        sel_opr_a,
    output logic        sel_opr_b,
    output imm_type_e   imm_type,
    output logic        jump,
    output logic        branch,
    output logic        reads_rs1,
    output logic        reads_rs2,
    output logic        illegal,
    output wb_ctrl_t    wb
);
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       alt;

    assign opcode = inst[6:0];
    assign func3  = inst[14:12];
    assign alt    = inst[31:25] == F7_ALT;

    always_comb begin
        aluop     = ALU_ADD;
        sel_opr_a = 1'b0;
        sel_opr_b = 1'b1;
        imm_type  = IMM_I;
        jump      = 1'b0;
        branch    = 1'b0;
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b0;
        illegal   = 1'b0;
        wb        = '{rf_en: 1'b1, sel_wb: WB_ALU, rd: inst[11:7], mem_rd: 1'b0, mem_wr: 1'b0, mem_size: 3'b000};
        case (opcode)
            OP_R:      begin aluop = alu_func(func3, alt, alt); sel_opr_b = 1'b0; reads_rs2 = 1'b1; end
            OP_IMM:    aluop = alu_func(func3, 1'b0, alt);
            OP_LOAD:   begin wb.sel_wb = WB_MEM; wb.mem_rd = 1'b1; wb.mem_size = func3; end
            OP_STORE:  begin imm_type = IMM_S; reads_rs2 = 1'b1; wb.rf_en = 1'b0; wb.mem_wr = 1'b1; wb.mem_size = func3; end
            OP_BRANCH: begin sel_opr_a = 1'b1; imm_type = IMM_B; branch = 1'b1; reads_rs2 = 1'b1; wb.rf_en = 1'b0; end
            OP_JAL:    begin sel_opr_a = 1'b1; imm_type = IMM_J; jump = 1'b1; reads_rs1 = 1'b0; wb.sel_wb = WB_PC4; end
            OP_JALR:   begin jump = 1'b1; wb.sel_wb = WB_PC4; end
            OP_LUI:    begin aluop = ALU_PASS_B; imm_type = IMM_U; reads_rs1 = 1'b0; end
            OP_AUIPC:  begin sel_opr_a = 1'b1; imm_type = IMM_U; reads_rs1 = 1'b0; end
            default:   begin illegal = 1'b1; sel_opr_b = 1'b0; reads_rs1 = 1'b0; wb.rf_en = 1'b0; end
        endcase
        if (wb.rd == 5'd0) wb.rf_en = 1'b0;
    end
endmodule

// File: rtl/pipe_controller.sv
// pipe_controller: pipelined control for the 3-stage RV32I core -- decode, MEM/WB control
// register, forwarding, redirect flush and the data-memory wait/timeout stall FSM.
module pipe_controller
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int FLUSH_DEPTH = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        inst_de,
    input  logic               inst_valid,
    input  logic               br_taken,
    input  logic               dmem_ready,
    output logic [ALUOP_W-1:0] aluop,
    output logic               sel_opr_a,
    output logic               sel_opr_b,
    output logic [2:0]         imm_type,
    output logic               sel_pc,
    output logic               fwd_a,
    output logic               fwd_b,
    output logic               flush_de,
    output logic               stall,
    output logic               illegal,
    output logic               rf_en_wb,
    output logic [1:0]         sel_wb_wb,
    output logic [4:0]         rd_wb,
    output logic               mem_rd_wb,
    output logic               mem_wr_wb,
    output logic [2:0]         mem_size_wb,
    output logic               mem_err
);
    aluop_e     dec_aluop;
    imm_type_e  dec_imm;
    wb_ctrl_t   dec_wb, wb_q;
    mem_state_e state, state_next;
    logic       dec_a, dec_b, dec_jump, dec_branch, dec_rs1, dec_rs2, dec_illegal;
    logic [7:0] mem_cnt, mem_cnt_next;
    logic [1:0] flush_cnt;
    logic       bubble, redirect, abort;

    ctrl_decode u_decode (
        .inst      (inst_de),
        .aluop     (dec_aluop),
        .sel_opr_a (dec_a),
        .sel_opr_b (dec_b),
        .imm_type  (dec_imm),
        .jump      (dec_jump),
        .branch    (dec_branch),
        .reads_rs1 (dec_rs1),
        .reads_rs2 (dec_rs2),
        .illegal   (dec_illegal),
        .wb        (dec_wb)
    );

    assign bubble    = !inst_valid || flush_cnt != 2'd0 || dec_illegal;
    assign illegal   = inst_valid && dec_illegal;
    assign aluop     = ALUOP_W'(bubble ? ALU_ADD : dec_aluop);
    assign sel_opr_a = !bubble && dec_a;
    assign sel_opr_b = !bubble && dec_b;
    assign imm_type  = bubble ? IMM_I : dec_imm;
    // a stalled control transfer waits in DE and redirects on its first free cycle
    assign redirect  = !bubble && !stall && (dec_jump || (dec_branch && br_taken));
    assign sel_pc    = redirect;
    assign flush_de  = rst_n && !stall && (redirect || flush_cnt != 2'd0);
    assign fwd_a     = !bubble && dec_rs1 && wb_q.rf_en && wb_q.rd != 5'd0 && wb_q.rd == inst_de[19:15];
    assign fwd_b     = !bubble && dec_rs2 && wb_q.rf_en && wb_q.rd != 5'd0 && wb_q.rd == inst_de[24:20];

    assign rf_en_wb    = wb_q.rf_en;
    assign sel_wb_wb   = wb_q.sel_wb;
    assign rd_wb       = wb_q.rd;
    assign mem_rd_wb   = wb_q.mem_rd;
    assign mem_wr_wb   = wb_q.mem_wr;
    assign mem_size_wb = wb_q.mem_size;

    always_comb begin
        state_next   = state;
        mem_cnt_next = mem_cnt;
        stall        = 1'b0;
        abort        = 1'b0;
        if (state == S_IDLE) begin
            if ((wb_q.mem_rd || wb_q.mem_wr) && !dmem_ready) begin
                stall        = 1'b1;
                mem_cnt_next = 8'd1;
                state_next   = S_WAIT;
            end
        end else if (dmem_ready) begin
            state_next   = S_IDLE;
            mem_cnt_next = 8'd0;
        end else if (mem_cnt == 8'(MEM_TIMEOUT)) begin
            abort        = 1'b1;
            state_next   = S_IDLE;
            mem_cnt_next = 8'd0;
        end else begin
            stall        = 1'b1;
            mem_cnt_next = mem_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mem_cnt   <= 8'd0;
            flush_cnt <= 2'd0;
            wb_q      <= '0;
            mem_err   <= 1'b0;
        end else begin
            state   <= state_next;
            mem_cnt <= mem_cnt_next;
            mem_err <= abort;
            if (!stall)
                flush_cnt <= redirect ? 2'(FLUSH_DEPTH - 1) : (flush_cnt != 2'd0 ? flush_cnt - 2'd1 : 2'd0);
            if (abort || (!stall && bubble))
                wb_q <= '0;
            else if (!stall)
                wb_q <= dec_wb;
        end
    end
endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: directed checks of decode, forwarding, flush, memory stall/timeout and reset
module tb_pipe_controller;
    localparam logic [31:0] ADD5  = 32'h002082B3;
    localparam logic [31:0] SUB65 = 32'h40528333;
    localparam logic [31:0] ADD0  = 32'h00208033;
    localparam logic [31:0] SUB60 = 32'h40000333;
    localparam logic [31:0] BEQ   = 32'h00208063;
    localparam logic [31:0] LW3   = 32'h0000A183;
    localparam logic [31:0] JAL1  = 32'h000000EF;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ILL   = 32'h00000000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] inst_de = NOP;
    logic        inst_valid = 1'b0, br_taken = 1'b0, dmem_ready = 1'b1;
    logic [3:0]  aluop;
    logic [2:0]  imm_type, mem_size_wb;
    logic [1:0]  sel_wb_wb;
    logic [4:0]  rd_wb;
    logic        sel_opr_a, sel_opr_b, sel_pc, fwd_a, fwd_b, flush_de, stall, illegal;
    logic        rf_en_wb, mem_rd_wb, mem_wr_wb, mem_err;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    pipe_controller #(.ALUOP_W(4), .FLUSH_DEPTH(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .inst_de(inst_de), .inst_valid(inst_valid),
        .br_taken(br_taken), .dmem_ready(dmem_ready), .aluop(aluop),
        .sel_opr_a(sel_opr_a), .sel_opr_b(sel_opr_b), .imm_type(imm_type),
        .sel_pc(sel_pc), .fwd_a(fwd_a), .fwd_b(fwd_b), .flush_de(flush_de),
        .stall(stall), .illegal(illegal), .rf_en_wb(rf_en_wb), .sel_wb_wb(sel_wb_wb),
        .rd_wb(rd_wb), .mem_rd_wb(mem_rd_wb), .mem_wr_wb(mem_wr_wb),
        .mem_size_wb(mem_size_wb), .mem_err(mem_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] inst, input logic valid, input logic br, input logic rdy);
        @(negedge clk);
        inst_de = inst; inst_valid = valid; br_taken = br; dmem_ready = rdy;
        #1;
    endtask

    initial begin
        step(ADD5, 1, 0, 1);
        check("rst rf_en_wb", rf_en_wb, 0);
        check("rst rd_wb", rd_wb, 0);
        check("rst stall", stall, 0);
        check("rst flush_de", flush_de, 0);
        check("rst mem_err", mem_err, 0);
        step(ADD5, 1, 0, 1);
        check("rst hold rf_en_wb", rf_en_wb, 0);
        rst_n = 1'b1;
        step(SUB65, 1, 0, 1);
        check("post-rst rf_en_wb", rf_en_wb, 1);
        check("post-rst rd_wb", rd_wb, 5);
        check("sub fwd_a", fwd_a, 1);
        check("sub fwd_b", fwd_b, 1);
        check("sub aluop", aluop, 1);
        check("sub sel_opr_b", sel_opr_b, 0);
        step(ADD0, 1, 0, 1);
        check("sub wb rd", rd_wb, 6);
        step(SUB60, 1, 0, 1);
        check("x0 rf_en_wb", rf_en_wb, 0);
        check("x0 fwd_a", fwd_a, 0);
        check("x0 fwd_b", fwd_b, 0);

        step(BEQ, 1, 1, 1);
        check("beq sel_pc", sel_pc, 1);
        check("beq flush c0", flush_de, 1);
        check("beq sel_opr_a", sel_opr_a, 1);
        check("beq imm_type", imm_type, 2);
        step(NOP, 1, 0, 1);
        check("beq flush c1", flush_de, 1);
        check("beq sel_pc c1", sel_pc, 0);
        check("beq no wb", rf_en_wb, 0);
        step(ADD5, 1, 0, 1);
        check("beq flush c2", flush_de, 0);
        step(BEQ, 1, 0, 1);
        check("beq nt sel_pc", sel_pc, 0);
        check("beq nt flush", flush_de, 0);
        check("add wb after flush", rf_en_wb, 1);

        step(LW3, 1, 0, 1);
        check("lw sel_opr_b", sel_opr_b, 1);
        check("lw aluop", aluop, 0);
        step(ADD5, 1, 0, 0);
        check("lw stall 1", stall, 1);
        check("lw mem_rd_wb", mem_rd_wb, 1);
        check("lw mem_size_wb", mem_size_wb, 2);
        check("lw rd_wb", rd_wb, 3);
        step(ADD5, 1, 0, 0);
        check("lw stall 2", stall, 1);
        step(ADD5, 1, 0, 0);
        check("lw stall 3", stall, 1);
        step(ADD5, 1, 0, 1);
        check("lw ready stall", stall, 0);
        check("lw sel_wb_wb", sel_wb_wb, 1);
        check("lw rf_en_wb", rf_en_wb, 1);
        step(NOP, 1, 0, 1);
        check("after lw rd_wb", rd_wb, 5);
        check("after lw stall", stall, 0);

        step(LW3, 1, 0, 1);
        step(JAL1, 1, 0, 0);
        check("jal stall", stall, 1);
        check("jal stalled sel_pc", sel_pc, 0);
        check("jal stalled flush", flush_de, 0);
        step(JAL1, 1, 0, 0);
        check("jal stalled sel_pc 2", sel_pc, 0);
        step(JAL1, 1, 0, 1);
        check("jal go sel_pc", sel_pc, 1);
        check("jal go flush", flush_de, 1);
        step(NOP, 1, 0, 1);
        check("jal c1 sel_pc", sel_pc, 0);
        check("jal c1 flush", flush_de, 1);
        check("jal wb sel", sel_wb_wb, 2);
        check("jal wb rd", rd_wb, 1);
        step(NOP, 1, 0, 1);
        check("jal c2 flush", flush_de, 0);

        step(LW3, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(NOP, 1, 0, 0);
            check($sformatf("to stall %0d", i), stall, 1);
            check($sformatf("to err %0d", i), mem_err, 0);
        end
        step(NOP, 1, 0, 0);
        check("to abort stall", stall, 0);
        step(NOP, 1, 0, 0);
        check("to mem_err", mem_err, 1);
        check("to rf_en_wb", rf_en_wb, 0);
        check("to mem_rd_wb", mem_rd_wb, 0);
        check("to idle stall", stall, 0);
        step(NOP, 1, 0, 0);
        check("to mem_err pulse", mem_err, 0);

        step(LW3, 1, 0, 1);
        step(NOP, 1, 0, 0);
        check("rw stall 1", stall, 1);
        step(NOP, 1, 0, 0);
        check("rw stall 2", stall, 1);
        rst_n = 1'b0;
        inst_de = JAL1;
        #1;
        check("rw rst stall", stall, 0);
        check("rw rst mem_rd_wb", mem_rd_wb, 0);
        check("rw rst flush", flush_de, 0);
        inst_de = NOP;
        @(negedge clk);
        rst_n = 1'b1;
        step(NOP, 1, 0, 0);
        check("rw idle stall", stall, 0);

        step(ADD5, 1, 0, 1);
        step(ILL, 1, 0, 1);
        check("ill flag", illegal, 1);
        check("ill aluop", aluop, 0);
        check("ill sel_opr_b", sel_opr_b, 0);
        check("ill sel_pc", sel_pc, 0);
        check("ill prev wb", rf_en_wb, 1);
        step(NOP, 1, 0, 1);
        check("ill no wb", rf_en_wb, 0);
        step(ILL, 0, 0, 1);
        check("ill invalid slot", illegal, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
- Parametrised, pipelined successor to the combinational decode controller for the 3-stage (IF | DE/EX | MEM/WB) RV32I core.
- Decodes the full RV32I base set in DE/EX: R, I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC.
- Registers write-back/memory controls into MEM/WB.
- Generates forwarding selects, control-transfer flush, and a data-memory wait/timeout stall FSM.

Parameters:
- ALUOP_W, 4, width of aluop.
- FLUSH_DEPTH, 1, number of cycles the IF/DE register is flushed after a redirect (1..3).
- MEM_TIMEOUT, 15, maximum stalled cycles waiting for dmem_ready before abort (1..255).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- inst_de  in  32  instruction in DE/EX.
- inst_valid  in  1  inst_de holds a real instruction.
- br_taken  in  1  branch comparator result for inst_de.
- dmem_ready  in  1  data memory completes the MEM/WB access this cycle.
- aluop  out  ALUOP_W  ALU operation.
- sel_opr_a  out  1  0 = rs1, 1 = PC.
- sel_opr_b  out  1  0 = rs2, 1 = immediate.
- imm_type  out  3  immediate format.
- sel_pc  out  1  redirect PC to ALU result.
- fwd_a / fwd_b  out  1 each  forward MEM/WB result to operand a / b.
- flush_de  out  1  IF/DE register loads NOP next edge.
- stall  out  1  freeze PC, IF/DE and MEM/WB.
- illegal  out  1  unsupported opcode in DE (valid slot only).
- rf_en_wb  out  1  register write in MEM/WB.
- sel_wb_wb  out  2  write-back source.
- rd_wb  out  5  destination register.
- mem_rd_wb / mem_wr_wb  out  1 each  load / store.
- mem_size_wb  out  3  func3 of the load/store.
- mem_err  out  1  one-cycle timeout pulse.

Behaviour:
- Encodings:
  - aluop: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10.
  - imm_type: I 0, S 1, B 2, U 3, J 4.
  - sel_wb: 00 ALU, 01 MEM, 10 PC+4.
- Decode (combinational):
  - SUB/SRA/SRAI are selected by func7 = 0100000; any other func7 selects ADD/SRL/SRLI. No latch paths: every output has a default.
  - Load/store/JALR: rs1 + imm, ADD.
  - Branch: PC + imm, B-type immediate.
  - JAL: PC + imm, J-type immediate.
  - LUI: PASS_B, U-type immediate.
  - AUIPC: PC + imm, ADD.
- Bubble: when !inst_valid, flush counter nonzero, or illegal:
  - DE outputs are NOP (aluop ADD, all selects 0, sel_pc 0).
  - Nothing is written to MEM/WB.
- Redirect (sel_pc = 1): JAL, JALR, or branch with br_taken, in a non-bubble slot with stall = 0.
  - Same cycle: flush_de = 1.
  - Flush counter loads FLUSH_DEPTH-1 and keeps flush_de high for that many further cycles.
- MEM/WB register, on each clk edge:
  - stall = 1: hold.
  - Else bubble: clear.
  - Else load the decoded rf_en, sel_wb, rd, mem_rd, mem_wr, mem_size.
  - rf_en is forced 0 for rd = x0, stores and branches.
- Forwarding:
  - fwd_a = rf_en_wb & (rd_wb != 0) & (rd_wb == inst_de[19:15]) & (instruction reads rs1).
  - fwd_b uses inst_de[24:20] and is asserted for R, store and branch only.
- Memory FSM, states IDLE and WAIT:
  - IDLE: if (mem_rd_wb | mem_wr_wb) & !dmem_ready, then stall = 1, counter = 1, go to WAIT.
  - WAIT: stall = !dmem_ready, counter increments each stalled cycle.
  - dmem_ready = 1: stall = 0, go to IDLE.
  - Counter = MEM_TIMEOUT while still not ready: mem_err = 1, stall = 0, MEM/WB cleared (rf_en_wb = 0), go to IDLE.
- Simultaneous events:
  - stall beats redirect: sel_pc and flush_de are 0 while stall = 1. The branch stays in DE and redirects on the first unstalled cycle.
  - The flush counter does not decrement while stalled.
- Reset (asynchronous, any time, including in WAIT or mid-flush):
  - FSM to IDLE, counters 0.
  - All registered outputs 0 (rf_en_wb, sel_wb_wb, rd_wb, mem_rd_wb, mem_wr_wb, mem_size_wb, mem_err).
  - flush_de and stall therefore 0 while rst_n = 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams and the aluop_e, imm_type_e, sel_wb_e enums.
  - typedef wb_ctrl_t, a struct of rf_en, sel_wb, rd, mem_rd, mem_wr, mem_size.
- One sub-module, ctrl_decode: purely combinational opcode/func3/func7 decode to DE controls and a wb_ctrl_t.
- The top holds the MEM/WB register, flush counter, memory FSM and forwarding.

Test Plan:
- Reset: hold rst_n = 0 with a valid ADD present -> all registered outputs 0, stall 0. Release; one edge later rf_en_wb = 1, rd_wb = inst[11:7].
- Forwarding: ADD x5,x1,x2 then SUB x6,x5,x5 -> during SUB, fwd_a = fwd_b = 1, aluop = 1. Repeat with rd = x0 -> rf_en_wb = 0, fwd_a = fwd_b = 0.
- Taken branch, FLUSH_DEPTH = 2: BEQ with br_taken = 1 -> sel_pc = 1, flush_de high for exactly 2 cycles, no MEM/WB write from the branch. br_taken = 0 -> no flush.
- Load wait: LW x3 with dmem_ready low for 3 cycles -> stall high for exactly 3 cycles, then sel_wb_wb = 01, rf_en_wb = 1.
- Load wait overlapping a branch: JAL in DE while LW stalls -> sel_pc = 0 until ready, then 1 for one cycle.
- Timeout: MEM_TIMEOUT = 4, dmem_ready never high -> stall for 4 cycles, mem_err pulses once, rf_en_wb = 0, FSM back in IDLE. Assert rst_n low mid-WAIT -> stall drops immediately.
- Illegal: opcode 0000000 with inst_valid = 1 -> illegal = 1, NOP outputs, no MEM/WB write.
